// File: rtl/mmio_io_responder.sv
`timescale 1ns/1ps
// mmio_io_responder: four-register MMIO window (INPUT, EVENT, DISPLAY, COUNT) with synchronised
// switches, debounced buttons and press counters. Define MMIO_IRQ_EN to add the interrupt mask and irq port.
module mmio_io_responder #(
  parameter logic [6:0] BASE_ADDR       = 7'h7C,
  parameter int         DEBOUNCE_CYCLES = 1000000,
  parameter int         CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        CS,
  input  logic        WE,
  input  logic [6:0]  ADDR,
  inout  wire  [31:0] Mem_Bus,
  input  logic        SW0,
  input  logic        SW1,
  input  logic        SW2,
  input  logic        btnL,
  input  logic        btnR,
  output logic [15:0] display_value
`ifdef MMIO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic        hit;
  logic        rd_hit;
  logic        wr_hit;
  logic [1:0]  reg_sel;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic [1:0]  btn_raw;
  logic [1:0]  btn_db;
  logic [1:0]  press;

  logic [2:0]  sw_meta_q;
  logic [2:0]  sw_sync_q;

  logic [1:0]  event_q, event_d;
  logic [7:0]  cnt_l_q, cnt_l_d;
  logic [7:0]  cnt_r_q, cnt_r_d;
  logic [15:0] display_q, display_d;
`ifdef MMIO_IRQ_EN
  logic [1:0]  mask_q, mask_d;
  logic        irq_q;
`endif

  logic        unused_wdata;

  assign hit     = CS && (ADDR[6:2] == BASE_ADDR[6:2]);
  assign reg_sel = ADDR[1:0];
  // The bus is released while reset is held, even if a read is presented.
  assign rd_hit  = hit && !WE && !rst;
  assign wr_hit  = hit && WE;
  assign wdata   = Mem_Bus;
  assign Mem_Bus = rd_hit ? rdata : 32'bz;

  assign unused_wdata = ^wdata;
  assign btn_raw      = {btnR, btnL};

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= {SW2, SW1, SW0};
      sw_sync_q <= sw_meta_q;
    end
  end

  // Per-button synchroniser and debouncer; index 0 is btnL, index 1 is btnR.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_btn
      logic             meta_q;
      logic             sync_q;
      logic             db_q, db_d;
      logic [CNT_W-1:0] cnt_q, cnt_d;

      always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
          meta_q <= 1'b0;
          sync_q <= 1'b0;
          db_q   <= 1'b0;
          cnt_q  <= '0;
        end else begin
          meta_q <= btn_raw[gi];
          sync_q <= meta_q;
          db_q   <= db_d;
          cnt_q  <= cnt_d;
        end
      end

      always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q != db_q) begin
          if (cnt_q == CNT_LAST) begin
            db_d = sync_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      assign btn_db[gi] = db_q;
      assign press[gi]  = db_d & ~db_q;
    end
  endgenerate

  // A press on the same edge as a W1C keeps its bit; a COUNT write beats a press.
  always_comb begin
    event_d   = event_q;
    cnt_l_d   = cnt_l_q + {7'd0, press[0]};
    cnt_r_d   = cnt_r_q + {7'd0, press[1]};
    display_d = display_q;
`ifdef MMIO_IRQ_EN
    mask_d    = mask_q;
`endif
    if (wr_hit && reg_sel == 2'd1) begin
      event_d = event_q & ~wdata[1:0];
`ifdef MMIO_IRQ_EN
      mask_d  = wdata[17:16];
`endif
    end
    event_d = event_d | press;
    if (wr_hit && reg_sel == 2'd2) begin
      display_d = wdata[15:0];
    end
    if (wr_hit && reg_sel == 2'd3) begin
      cnt_l_d = 8'd0;
      cnt_r_d = 8'd0;
    end
  end

  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      event_q   <= '0;
      cnt_l_q   <= '0;
      cnt_r_q   <= '0;
      display_q <= '0;
    end else begin
      event_q   <= event_d;
      cnt_l_q   <= cnt_l_d;
      cnt_r_q   <= cnt_r_d;
      display_q <= display_d;
    end
  end

`ifdef MMIO_IRQ_EN
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= |(event_q & mask_q);
    end
  end

  assign irq = irq_q;
`endif

  always_comb begin
    rdata = '0;
    case (reg_sel)
      2'd0: rdata[4:0] = {btn_db[1], btn_db[0], sw_sync_q};
      2'd1: begin
        rdata[1:0] = event_q;
`ifdef MMIO_IRQ_EN
        rdata[17:16] = mask_q;
`endif
      end
      2'd2: rdata[15:0] = display_q;
      default: rdata[15:0] = {cnt_r_q, cnt_l_q};
    endcase
  end

  assign display_value = display_q;

endmodule
